// File: rtl/exibe_jogadas_pkg.sv
// ---------------------------------------------------------------------------
// exibe_jogadas_pkg
// Shared definitions for the play-display block: data width, timer width
// and the FSM state codes. The state codes double as the db_estado debug
// output, so their numeric values are part of the external interface.
// ---------------------------------------------------------------------------
package exibe_jogadas_pkg;

   localparam int LARGURA       = 4;   // width of address, plays and limits
   localparam int LARGURA_TEMPO = 12;  // width of the lit/dark timers

   typedef enum logic [3:0] {
      INICIAL = 4'h0,
      CARREGA = 4'h1,
      ACESO   = 4'h2,
      APAGADO = 4'h3,
      PROXIMO = 4'h4,
      FIM     = 4'hF
   } estado_t;

endpackage

// File: rtl/exibe_jogadas_contador_tempo.sv
// ---------------------------------------------------------------------------
// contador_tempo
// 12-bit up-counter used to time one FSM state.
//   clock      : system clock
//   reset      : asynchronous active-high reset, clears the count
//   i_limpa    : synchronous clear (has priority over counting)
//   i_habilita : count enable
//   o_fim      : high while enabled and the count equals VALOR_FIM
// With VALOR_FIM = N-1 the owning state lasts exactly N cycles, provided
// the count is cleared when the state is entered.
// ---------------------------------------------------------------------------
module contador_tempo
   import exibe_jogadas_pkg::*;
#(
   parameter int VALOR_FIM = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic i_limpa,
   input  logic i_habilita,
   output logic o_fim
);

   localparam logic [LARGURA_TEMPO-1:0] C_FIM = LARGURA_TEMPO'(VALOR_FIM);
   localparam logic [LARGURA_TEMPO-1:0] C_UM  = LARGURA_TEMPO'(1);

   logic [LARGURA_TEMPO-1:0] r_contagem;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_contagem <= '0;
      end else if (i_limpa) begin
         r_contagem <= '0;
      end else if (i_habilita) begin
         r_contagem <= r_contagem + C_UM;
      end
   end

   assign o_fim = i_habilita && (r_contagem == C_FIM);

endmodule

// File: rtl/exibe_jogadas.sv
// ---------------------------------------------------------------------------
// exibe_jogadas
// Shows a stored sequence of one-hot plays on four LEDs, one entry at a
// time: each entry is lit for TEMPO_ACESO cycles and followed by
// TEMPO_APAGADO dark cycles, from address 0 up to the limit latched at
// start. A one-cycle pronto pulse marks the end of the run.
//
// Parameters
//   TEMPO_ACESO   : lit cycles per entry (2..4095)
//   TEMPO_APAGADO : dark cycles per entry (1..4095)
// Ports
//   clock        in   system clock
//   reset        in   asynchronous active-high reset
//   iniciar      in   start request (level-sampled in inicial)
//   parar        in   abort request (only with EXIBE_PARAR_EN defined)
//   limite       in   [3:0] index of the last entry to show
//   dado_memoria in   [3:0] ROM data, valid one cycle after endereco
//   endereco     out  [3:0] ROM address of the current entry
//   leds         out  [3:0] pattern shown to the player
//   exibindo     out  high while a run is in progress
//   pronto       out  one-cycle pulse at the end of a run
//   db_estado    out  [3:0] current state code
// Configuration
//   EXIBE_PARAR_EN : adds the parar input, which returns the FSM to inicial
//                    from any other state, ahead of every other transition.
// ---------------------------------------------------------------------------
module exibe_jogadas
   import exibe_jogadas_pkg::*;
#(
   parameter int TEMPO_ACESO   = 500,
   parameter int TEMPO_APAGADO = 250
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               iniciar,
`ifdef EXIBE_PARAR_EN
   input  logic               parar,
`endif
   input  logic [LARGURA-1:0] limite,
   input  logic [LARGURA-1:0] dado_memoria,
   output logic [LARGURA-1:0] endereco,
   output logic [LARGURA-1:0] leds,
   output logic               exibindo,
   output logic               pronto,
   output logic [3:0]         db_estado
);

   localparam logic [LARGURA-1:0] C_UM = LARGURA'(1);

   estado_t            r_estado;
   estado_t            w_prox_estado;
   logic [LARGURA-1:0] r_endereco;
   logic [LARGURA-1:0] r_limite;
   logic               w_troca;
   logic               w_fim_aceso;
   logic               w_fim_apagado;

   // Any state change clears both timers, so every timed state starts
   // counting from zero.
   assign w_troca = (w_prox_estado != r_estado);

   contador_tempo #(
      .VALOR_FIM (TEMPO_ACESO - 1)
   ) u_tempo_aceso (
      .clock      (clock),
      .reset      (reset),
      .i_limpa    (w_troca),
      .i_habilita (r_estado == ACESO),
      .o_fim      (w_fim_aceso)
   );

   contador_tempo #(
      .VALOR_FIM (TEMPO_APAGADO - 1)
   ) u_tempo_apagado (
      .clock      (clock),
      .reset      (reset),
      .i_limpa    (w_troca),
      .i_habilita (r_estado == APAGADO),
      .o_fim      (w_fim_apagado)
   );

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_estado <= INICIAL;
      end else begin
         r_estado <= w_prox_estado;
      end
   end

   // Next-state logic
   always_comb begin
      w_prox_estado = r_estado;
      case (r_estado)
         INICIAL: if (iniciar) w_prox_estado = CARREGA;
         CARREGA: w_prox_estado = ACESO;
         ACESO:   if (w_fim_aceso) w_prox_estado = APAGADO;
         APAGADO: begin
            if (w_fim_apagado) begin
               w_prox_estado = (r_endereco == r_limite) ? FIM : PROXIMO;
            end
         end
         PROXIMO: w_prox_estado = CARREGA;
         FIM:     w_prox_estado = INICIAL;
         default: w_prox_estado = INICIAL;
      endcase
`ifdef EXIBE_PARAR_EN
      if (parar && (r_estado != INICIAL)) begin
         w_prox_estado = INICIAL;
      end
`endif
   end

   // Address and latched limit. Both updates are keyed on the actual
   // transition into carrega so an abort never moves the address.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_endereco <= '0;
         r_limite   <= '0;
      end else if (w_prox_estado == CARREGA) begin
         if (r_estado == INICIAL) begin
            r_endereco <= '0;
            r_limite   <= limite;
         end else if (r_estado == PROXIMO) begin
            r_endereco <= r_endereco + C_UM;
         end
      end
   end

   assign endereco = r_endereco;

   // Output logic
   always_comb begin
      leds      = '0;
      exibindo  = 1'b0;
      pronto    = 1'b0;
      db_estado = r_estado;
      case (r_estado)
         CARREGA: exibindo = 1'b1;
         ACESO: begin
            exibindo = 1'b1;
            leds     = dado_memoria;
         end
         APAGADO: exibindo = 1'b1;
         PROXIMO: exibindo = 1'b1;
         FIM:     pronto   = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_exibe_jogadas.sv
// ---------------------------------------------------------------------------
// tb_exibe_jogadas
// Directed bench for exibe_jogadas with TEMPO_ACESO=4, TEMPO_APAGADO=2.
// Stimulus pushes the expected flashes and pronto pulses into a queue; an
// independent monitor detects those events on the DUT outputs and checks
// them against the queue head.
// ---------------------------------------------------------------------------
module tb_exibe_jogadas;
   import exibe_jogadas_pkg::*;

   localparam int TA = 4;
   localparam int TP = 2;
   localparam int P  = TA + TP + 2;   // cycles per displayed entry

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       iniciar = 1'b0;
   logic [3:0] limite = 4'd0;
   logic [3:0] dado_memoria = 4'd0;
   logic [3:0] endereco;
   logic [3:0] leds;
   logic       exibindo;
   logic       pronto;
   logic [3:0] db_estado;
`ifdef EXIBE_PARAR_EN
   logic       parar = 1'b0;
`endif

   exibe_jogadas #(
      .TEMPO_ACESO   (TA),
      .TEMPO_APAGADO (TP)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .iniciar      (iniciar),
`ifdef EXIBE_PARAR_EN
      .parar        (parar),
`endif
      .limite       (limite),
      .dado_memoria (dado_memoria),
      .endereco     (endereco),
      .leds         (leds),
      .exibindo     (exibindo),
      .pronto       (pronto),
      .db_estado    (db_estado)
   );

   always #5 clock = ~clock;

   // Sequence ROM with one cycle of read latency
   logic [3:0] rom [16];
   always @(posedge clock) dado_memoria <= rom[endereco];

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int         tipo;    // 0 = flash, 1 = pronto
      int         ciclo;   // cycle of flash start / pronto
      logic [3:0] padrao;  // LED pattern (0 during pronto)
      logic [3:0] ender;   // address shown with the event
   } ev_t;

   ev_t esperado[$];
   int  n_run  = 0;
   int  n_fail = 0;

   task automatic verifica(input string nome, input int got, input int req);
      n_run++;
      if (got !== req) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d required %0d", nome, got, req);
      end else begin
         $display("[TB] ok %s = %0d", nome, got);
      end
   endtask

   task automatic confere(input int tipo, input int ciclo, input int dur,
                          input logic [3:0] pad, input logic [3:0] ender,
                          input logic exib);
      ev_t e;
      int  req_dur;
      n_run++;
      if (esperado.size() == 0) begin
         n_fail++;
         $display("[TB] FAIL unexpected_event: tipo=%0d cycle=%0d leds=%b end=%0d, none required",
                  tipo, ciclo, pad, ender);
         return;
      end
      e = esperado.pop_front();
      req_dur = (e.tipo == 0) ? TA : 0;
      if (tipo != e.tipo || ciclo != e.ciclo || dur != req_dur ||
          pad != e.padrao || ender != e.ender || exib != (e.tipo == 0)) begin
         n_fail++;
         $display("[TB] FAIL event: got tipo=%0d cycle=%0d dur=%0d leds=%b end=%0d exib=%0d required tipo=%0d cycle=%0d dur=%0d leds=%b end=%0d exib=%0d",
                  tipo, ciclo, dur, pad, ender, exib,
                  e.tipo, e.ciclo, req_dur, e.padrao, e.ender, (e.tipo == 0));
      end else begin
         $display("[TB] ok event tipo=%0d cycle=%0d leds=%b end=%0d", tipo, ciclo, pad, ender);
      end
   endtask

   // Monitor: a flash is reported when the LEDs go dark again, a pronto
   // on every cycle it is high. Reset discards a partially seen flash.
   initial begin
      logic [3:0] ant_leds;
      logic [3:0] fl_pad;
      logic [3:0] fl_end;
      logic       fl_exib;
      int         fl_ini;
      bit         fl_ativo;
      ant_leds = 4'd0;
      fl_pad   = 4'd0;
      fl_end   = 4'd0;
      fl_exib  = 1'b0;
      fl_ini   = 0;
      fl_ativo = 1'b0;
      forever begin
         @(negedge clock);
         if (reset) begin
            fl_ativo = 1'b0;
            ant_leds = 4'd0;
         end else begin
            if (leds != 4'd0 && ant_leds == 4'd0) begin
               fl_ativo = 1'b1;
               fl_ini   = cyc;
               fl_pad   = leds;
               fl_end   = endereco;
               fl_exib  = exibindo;
            end else if (leds == 4'd0 && ant_leds != 4'd0 && fl_ativo) begin
               fl_ativo = 1'b0;
               confere(0, fl_ini, cyc - fl_ini, fl_pad, fl_end, fl_exib);
            end
            if (pronto) confere(1, cyc, 0, leds, endereco, exibindo);
            ant_leds = leds;
         end
      end
   end

   // Expected events of a run whose inicial (start-sampling) cycle is s
   task automatic empurra(input int s, input int lim, input int nfl, input bit com_pronto);
      ev_t e;
      for (int i = 0; i < nfl; i++) begin
         e.tipo   = 0;
         e.ciclo  = s + 2 + P * i;
         e.padrao = rom[i];
         e.ender  = 4'(i);
         esperado.push_back(e);
      end
      if (com_pronto) begin
         e.tipo   = 1;
         e.ciclo  = s + P * (lim + 1);
         e.padrao = 4'd0;
         e.ender  = 4'(lim);
         esperado.push_back(e);
      end
   endtask

   // Called at a negedge with the FSM in inicial
   task automatic dispara(input int lim, input int nfl, input bit com_pronto, output int s);
      limite  = 4'(lim);
      iniciar = 1'b1;
      s       = cyc;
      empurra(s, lim, nfl, com_pronto);
      @(negedge clock);
      iniciar = 1'b0;
   endtask

   task automatic drena(input string nome, input int orcamento, input int end_req);
      int k;
      k = 0;
      while (esperado.size() != 0 && k < orcamento) begin
         @(negedge clock);
         k++;
      end
      verifica({nome, "_pending_events"}, esperado.size(), 0);
      esperado.delete();
      repeat (4) @(negedge clock);
      verifica({nome, "_db_estado_idle"}, db_estado, 0);
      verifica({nome, "_endereco_hold"}, endereco, end_req);
   endtask

   initial begin
      int s;
      for (int i = 0; i < 16; i++) rom[i] = 4'd0;

      // Asynchronous reset: outputs settle before any clock edge
      #1 reset = 1'b1;
      #1;
      verifica("rst_leds", leds, 0);
      verifica("rst_exibindo", exibindo, 0);
      verifica("rst_pronto", pronto, 0);
      verifica("rst_db_estado", db_estado, 0);
      verifica("rst_endereco", endereco, 0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;

      // Four-entry run; limite changes mid-run must be ignored
      rom[0] = 4'b0001; rom[1] = 4'b0010; rom[2] = 4'b0100; rom[3] = 4'b1000;
      dispara(3, 4, 1'b1, s);
      repeat (5) @(negedge clock);
      limite = 4'd0;
      drena("run4", 100, 3);

      // Single entry
      rom[0] = 4'b0100;
      dispara(0, 1, 1'b1, s);
      drena("run1", 40, 0);

      // Sixteen entries, no address wrap
      for (int i = 0; i < 16; i++) rom[i] = 4'(1 << (i % 4));
      dispara(15, 16, 1'b1, s);
      drena("run16", 300, 15);

      // Reset during the lit phase of entry 2
      rom[0] = 4'b0001; rom[1] = 4'b0010; rom[2] = 4'b0100; rom[3] = 4'b1000;
      dispara(3, 2, 1'b0, s);
      while (cyc < s + 2 + 2 * P + 1) @(negedge clock);
      verifica("pre_abort_leds", leds, 4);
      #2 reset = 1'b1;
      #1;
      verifica("abort_leds", leds, 0);
      verifica("abort_exibindo", exibindo, 0);
      verifica("abort_db_estado", db_estado, 0);
      verifica("abort_endereco", endereco, 0);
      @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      verifica("abort_pending_events", esperado.size(), 0);
      esperado.delete();
      dispara(0, 1, 1'b1, s);
      drena("restart", 40, 0);

      // iniciar held high: a second run starts right after the first
      rom[0] = 4'b0010; rom[1] = 4'b1000;
      limite  = 4'd1;
      iniciar = 1'b1;
      s = cyc;
      empurra(s, 1, 2, 1'b1);
      empurra(s + 2 * P + 1, 1, 2, 1'b1);
      repeat (20) @(negedge clock);
      iniciar = 1'b0;
      drena("backtoback", 100, 1);

`ifdef EXIBE_PARAR_EN
      // parar in the dark phase of entry 1
      rom[0] = 4'b0001; rom[1] = 4'b0010; rom[2] = 4'b0100; rom[3] = 4'b1000;
      dispara(3, 2, 1'b0, s);
      while (cyc < s + P + 2 + TA) @(negedge clock);
      verifica("pre_parar_db_estado", db_estado, 3);
      parar = 1'b1;
      @(negedge clock);
      parar = 1'b0;
      verifica("parar_db_estado", db_estado, 0);
      verifica("parar_leds", leds, 0);
      verifica("parar_exibindo", exibindo, 0);
      repeat (3 * P) @(negedge clock);
      verifica("parar_pending_events", esperado.size(), 0);
      esperado.delete();
`endif

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
